// File: rtl/down_count_monitor_pkg.sv
// Shared definitions for the down-counter monitor: state encodings and
// the per-edge sample classification bundle.
package down_count_monitor_pkg;

  localparam int COUNT_W_DEF = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COUNTING = 3'd1;
  localparam logic [2:0] S_AT_ZERO  = 3'd2;
  localparam logic [2:0] S_WRAPPED  = 3'd3;
  localparam logic [2:0] S_STALLED  = 3'd4;

  typedef struct packed {
    logic down;
    logic wrap;
    logic hold;
    logic jmp;
  } sample_t;

endpackage

// File: rtl/mon_stall_timer.sv
// Saturating hold-run timer; hit is high on any edge that leaves the
// run at or above LIMIT.
module mon_stall_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && q != LIM) begin
      q <= q + W'(1);
    end
  end

  assign hit = inc && !clr && (q >= LIM - W'(1));

endmodule

// File: rtl/down_count_monitor.sv
// Monitor for a 4-bit down-counter: classifies samples, tracks phase,
// pulses on wraps. Stall detection is built only with MON_STALL_DETECT_EN.
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int WRAP_W      = 8,
  parameter int STALL_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               enable_in,
  input  logic               clr_wraps,
  output logic               tc_pulse,
  output logic [WRAP_W-1:0]  wrap_count,
  output logic               jump,
  output logic               stall,
  output logic [2:0]         state_out
);

  logic [COUNT_W-1:0] count_q;
  logic               valid_q;
  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [2:0]         zc;
  logic               hit;
  logic               enter_wrap;
  sample_t            s;

  always_comb begin
    s.hold = (count_in == count_q);
    s.down = (count_in == count_q - COUNT_W'(1));
    s.wrap = (count_q == '0) && (count_in == '1);
    s.jmp  = !s.hold && !s.down;
  end

`ifdef MON_STALL_DETECT_EN
  mon_stall_timer #(
    .LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (valid_q && enable_in && s.hold),
    .clr   (!valid_q || !enable_in || !s.hold),
    .hit   (hit)
  );
`else
  assign hit = (STALL_LIMIT < 0);
`endif

  assign zc = (count_in == '0) ? S_AT_ZERO : S_COUNTING;

  always_comb begin
    state_nxt = state;
    if (valid_q) begin
      unique case (state)
        S_IDLE: begin
          if (s.down) state_nxt = zc;
        end
        S_COUNTING: begin
          if (s.jmp)       state_nxt = S_IDLE;
          else if (s.down) state_nxt = zc;
          else if (hit)    state_nxt = S_STALLED;
        end
        S_AT_ZERO: begin
          if (s.jmp)       state_nxt = S_IDLE;
          else if (s.wrap) state_nxt = S_WRAPPED;
          else if (hit)    state_nxt = S_STALLED;
        end
        S_WRAPPED: begin
          state_nxt = s.jmp ? S_IDLE : zc;
        end
        S_STALLED: begin
          if (s.jmp)       state_nxt = S_IDLE;
          else if (s.down) state_nxt = zc;
          else if (!enable_in)
            state_nxt = (count_q == '0) ? S_AT_ZERO : S_COUNTING;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // WRAPPED never loops on itself, so any transition into it is a wrap
  assign enter_wrap = (state_nxt == S_WRAPPED) && (state != S_WRAPPED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      valid_q    <= 1'b0;
      state      <= S_IDLE;
      jump       <= 1'b0;
      wrap_count <= '0;
    end else begin
      count_q <= count_in;
      valid_q <= 1'b1;
      state   <= state_nxt;
      jump    <= valid_q && s.jmp;
      if (clr_wraps) begin
        wrap_count <= WRAP_W'(enter_wrap);
      end else if (enter_wrap && wrap_count != '1) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end
    end
  end

  assign tc_pulse  = (state == S_WRAPPED);
  assign stall     = (state == S_STALLED);
  assign state_out = state;

endmodule
